bin2rns_seq: RTL

Parametrised, handshaked binary-to-RNS converter. It succeeds the fixed four-channel (3,5,7,8) lookup converter. Takes a W-bit two's-complement integer and produces N_CH residues against a configurable moduli set, using a bit-serial shift-and-reduce datapath with a sign-correction step and a dynamic-range overflow flag. It sits at the front of the RNS datapath, feeding the per-channel arithmetic units.

---
 rtl/bin2rns_seq_if.sv | 24 ++
 rtl/bin2rns_seq.sv | 98 +++++++++
 2 files changed

// File: rtl/bin2rns_seq_if.sv
// rtl/bin2rns_seq_if.sv - input/output handshake bundle for the binary-to-RNS converter
interface bin2rns_seq_if #(
    parameter int W    = 32,
    parameter int N_CH = 4,
    parameter int RW   = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         n;
    logic                 out_valid;
    logic                 out_ready;
    logic [N_CH*RW-1:0]   res;
    logic                 ovf;

    modport master (
        output in_valid, n, out_ready,
        input  in_ready, out_valid, res, ovf
    );

    modport slave (
        input  in_valid, n, out_ready,
        output in_ready, out_valid, res, ovf
    );
endinterface

// File: rtl/bin2rns_seq.sv
// rtl/bin2rns_seq.sv - bit-serial binary-to-RNS converter with sign fix-up and range flag
module bin2rns_seq #(
    parameter int                W      = 32,
    parameter int                N_CH   = 4,
    parameter int                RW     = 3,
    parameter logic [8*N_CH-1:0] MODULI = {8'd8, 8'd7, 8'd5, 8'd3},
    parameter int                DR     = 840
) (
    input  logic          clk,
    input  logic          reset,
    bin2rns_seq_if.slave  bus
);
    localparam int CW = $clog2(W);
    localparam logic signed [63:0] HALF = 64'(DR / 2);

    typedef enum logic [1:0] {IDLE, CONV, FIX, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       cnt;
    logic                neg;
    logic [W-1:0]        mag;
    logic                ovf_r;
    logic signed [63:0]  n_ext;

    // Sign-extend the input so the range test works for any W
    assign n_ext   = 64'($signed(bus.n));
    assign bus.ovf = ovf_r;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and handshake outputs; both handshakes are masked while reset is high
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = (state == IDLE) && !reset;
        bus.out_valid = (state == DONE) && !reset;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = CONV;
            CONV:    if (cnt == CW'(W - 1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture sign/magnitude/range on accept; shift magnitude MSB-first during conversion
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            neg   <= 1'b0;
            mag   <= '0;
            ovf_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    neg   <= bus.n[W-1];
                    mag   <= bus.n[W-1] ? (~bus.n + W'(1)) : bus.n;
                    ovf_r <= (n_ext < -HALF) || (n_ext >= HALF);
                    cnt   <= '0;
                end
                CONV: begin
                    mag <= mag << 1;
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam logic [RW:0] M = (RW + 1)'(MODULI[8*i +: 8]);

        logic [RW-1:0] r;
        logic [RW:0]   t;

        // Doubling plus the incoming bit never exceeds 2m-1, so one subtract reduces it
        assign t = {r, mag[W-1]};
        assign bus.res[RW*i +: RW] = r;

        // Per-channel residue accumulator: clear, shift-and-reduce, then negate for negative inputs
        always_ff @(posedge clk) begin
            if (reset) begin
                r <= '0;
            end else begin
                case (state)
                    IDLE: if (bus.in_valid) r <= '0;
                    CONV: r <= (t >= M) ? RW'(t - M) : RW'(t);
                    FIX:  if (neg && (r != '0)) r <= RW'(M - {1'b0, r});
                    default: ;
                endcase
            end
        end
    end
endmodule
